// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one data memory port between load queue (L) and store buffer (S); optional checks via DMEM_ARB_ALIGN_CHECK_EN.
// Latency: ack two cycles after the sampling edge, one access per 3 cycles; requesters hold req until ack, no other backpressure.
module dmem_arbiter #(
   parameter logic [31:0] BASE_ADDR   = 32'h10010000,
   parameter int          DEPTH_WORDS = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        l_req,
   input  logic [31:0] l_addr,
   input  logic [1:0]  l_size,
   input  logic        l_sign,
   output logic        l_ack,
   output logic [31:0] l_rdata,
   output logic        l_err,
   input  logic        s_req,
   input  logic [31:0] s_addr,
   input  logic [1:0]  s_size,
   input  logic [31:0] s_wdata,
   output logic        s_ack,
   output logic        s_err,
   output logic        mem_ena,
   output logic        mem_wena,
   output logic [1:0]  mem_w_cs,
   output logic [1:0]  mem_r_cs,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q;
   logic        last_s_q;
   logic        port_s_q;
   logic        sign_q;
   logic        err_q;
   logic        l_ack_q;
   logic        l_err_q;
   logic [31:0] l_rdata_q;
   logic        s_ack_q;
   logic        s_err_q;
   logic        mem_ena_q;
   logic        mem_wena_q;
   logic [1:0]  mem_w_cs_q;
   logic [1:0]  mem_r_cs_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;

   logic        gnt_s_d;
   logic [31:0] sel_addr_d;
   logic [1:0]  sel_size_d;
   logic        err_d;
   logic [31:0] ext_d;

   if (DEPTH_WORDS < 1 || BASE_ADDR[1:0] != 2'b00) begin : g_param_chk
      $error("dmem_arbiter: DEPTH_WORDS must be positive and BASE_ADDR word aligned");
   end

   // On a tie the port that did not win last time is served.
   always_comb begin
      gnt_s_d    = s_req && (!l_req || !last_s_q);
      sel_addr_d = gnt_s_d ? s_addr : l_addr;
      sel_size_d = gnt_s_d ? s_size : l_size;
   end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   localparam logic [32:0] ADDR_END = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

   always_comb begin
      err_d = 1'b0;
      if (sel_size_d == 2'b00) err_d = 1'b1;
      if (sel_size_d == 2'b01 && sel_addr_d[1:0] != 2'b00) err_d = 1'b1;
      if (sel_size_d == 2'b10 && sel_addr_d[0]) err_d = 1'b1;
      if (sel_addr_d < BASE_ADDR || {1'b0, sel_addr_d} >= ADDR_END) err_d = 1'b1;
   end
`else
   assign err_d = 1'b0;
`endif

   // Memory returns half/byte data zero-filled; only the upper bits need fixing.
   always_comb begin
      ext_d = mem_rdata;
      case (mem_r_cs_q)
         2'b10:   ext_d = {{16{sign_q & mem_rdata[15]}}, mem_rdata[15:0]};
         2'b11:   ext_d = {{24{sign_q & mem_rdata[7]}}, mem_rdata[7:0]};
         default: ext_d = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_s_q    <= 1'b1;
         port_s_q    <= 1'b0;
         sign_q      <= 1'b0;
         err_q       <= 1'b0;
         l_ack_q     <= 1'b0;
         l_err_q     <= 1'b0;
         l_rdata_q   <= 32'h0;
         s_ack_q     <= 1'b0;
         s_err_q     <= 1'b0;
         mem_ena_q   <= 1'b0;
         mem_wena_q  <= 1'b0;
         mem_w_cs_q  <= 2'b00;
         mem_r_cs_q  <= 2'b00;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (l_req || s_req) begin
                  state_q     <= ACC;
                  port_s_q    <= gnt_s_d;
                  last_s_q    <= gnt_s_d;
                  sign_q      <= l_sign;
                  err_q       <= err_d;
                  mem_ena_q   <= !err_d;
                  mem_wena_q  <= gnt_s_d && !err_d;
                  mem_w_cs_q  <= (gnt_s_d && !err_d) ? sel_size_d : 2'b00;
                  mem_r_cs_q  <= (!gnt_s_d && !err_d) ? sel_size_d : 2'b00;
                  mem_addr_q  <= err_d ? 32'h0 : sel_addr_d;
                  mem_wdata_q <= (gnt_s_d && !err_d) ? s_wdata : 32'h0;
               end
            end
            ACC: begin
               state_q     <= RESP;
               mem_ena_q   <= 1'b0;
               mem_wena_q  <= 1'b0;
               mem_w_cs_q  <= 2'b00;
               mem_r_cs_q  <= 2'b00;
               mem_addr_q  <= 32'h0;
               mem_wdata_q <= 32'h0;
               if (port_s_q) begin
                  s_ack_q <= 1'b1;
                  s_err_q <= err_q;
               end else begin
                  l_ack_q   <= 1'b1;
                  l_err_q   <= err_q;
                  l_rdata_q <= err_q ? 32'h0 : ext_d;
               end
            end
            RESP: begin
               state_q <= IDLE;
               l_ack_q <= 1'b0;
               l_err_q <= 1'b0;
               s_ack_q <= 1'b0;
               s_err_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Reset gates the memory strobes combinationally so an aborted ACC never writes.
   assign mem_ena   = mem_ena_q & rst_n;
   assign mem_wena  = mem_wena_q & rst_n;
   assign mem_w_cs  = mem_w_cs_q & {2{rst_n}};
   assign mem_r_cs  = mem_r_cs_q & {2{rst_n}};
   assign mem_addr  = mem_addr_q & {32{rst_n}};
   assign mem_wdata = mem_wdata_q & {32{rst_n}};

   assign l_ack   = l_ack_q;
   assign l_err   = l_err_q;
   assign l_rdata = l_rdata_q;
   assign s_ack   = s_ack_q;
   assign s_err   = s_err_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the data memory in the dynamic pipeline. It shares the single data memory port between the load queue (port L) and the store buffer (port S) using round-robin arbitration. For each access it drives the memory's enable, write-enable, size-select, address and write-data lines for exactly one cycle. On loads it captures and sign-/zero-extends the read data, and it returns a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h10010000: byte address of memory word 0.
- `DEPTH_WORDS`, default 2048: number of 32-bit words in the memory.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `l_req`  in  1  load request; held high until `l_ack`.
- `l_addr`  in  32  load byte address.
- `l_size`  in  2  load size: 01 word, 10 half, 11 byte (00 is illegal).
- `l_sign`  in  1  1 sign-extends half/byte results; 0 zero-extends them.
- `l_ack`  out  1  one-cycle pulse; `l_rdata` and `l_err` are valid while it is high.
- `l_rdata`  out  32  extended load result.
- `l_err`  out  1  access rejected; see Configuration.
- `s_req`  in  1  store request; held high until `s_ack`.
- `s_addr`  in  32  store byte address.
- `s_size`  in  2  store size, same encoding as `l_size`.
- `s_wdata`  in  32  store data; half/byte data sits in the low bits.
- `s_ack`  out  1  one-cycle pulse indicating the store has committed (or been rejected).
- `s_err`  out  1  access rejected.
- `mem_ena`, `mem_wena`  out  1 each  memory enable and write enable.
- `mem_w_cs`, `mem_r_cs`  out  2 each  memory write and read size selects.
- `mem_addr`, `mem_wdata`  out  32 each  memory byte address and write data.
- `mem_rdata`  in  32  combinational memory read data; half/byte values arrive zero-filled in the low bits.

## Operation
FSM states: IDLE, ACC, RESP.

IDLE:
- At a rising edge, if any `req` is high, pick a winner and latch its addr/size/wdata/sign and port id. Move to ACC.
- If only one `req` is high, that port wins.
- If both are high, the port not granted last wins. The last-grant register resets to S, so L wins the first tie.

ACC (exactly one cycle):
- `mem_ena` = `rst_n`; `mem_addr` and `mem_wdata` come from the latched fields.
- Store: `mem_wena`=1, `mem_w_cs`=size, `mem_r_cs`=00. The memory write commits at the edge that ends ACC.
- Load: `mem_wena`=0, `mem_r_cs`=size, `mem_w_cs`=00. At the edge that ends ACC, `mem_rdata` is extended and registered into `l_rdata`:
  - word: passed through unchanged.
  - half: bits 31:16 = `l_sign` && bit 15 ? all ones : zeros.
  - byte: bits 31:8 = `l_sign` && bit 7 ? all ones : zeros.
- Next state is RESP.

RESP (exactly one cycle):
- The granted port's `ack` is 1 and its `err` is valid.
- Both `req` inputs are ignored.
- Next state is IDLE.

Outside ACC, all `mem_*` outputs are 0.

## Timing
- Request sampled at edge E0; memory is driven during cycle E0–E1; `ack` is high during cycle E1–E2; IDLE is re-entered at E2. Load latency is two cycles from the sampling edge.
- Maximum throughput is one access every 3 cycles.
- Requesters must drop `req` by E2. A `req` still high in IDLE is treated as a new request.
- Request inputs must stay stable from assertion through the sampling edge E0. Later changes are ignored because the fields are latched.
- Reset values: state IDLE, `l_ack`=`s_ack`=0, `l_err`=`s_err`=0, `l_rdata`=0, all `mem_*` outputs 0, last-grant register = S.
- Reset asserted during ACC:
  - `mem_ena` is gated low combinationally, so no memory write occurs at that edge.
  - The FSM goes to IDLE; no `ack` is issued and the request is dropped.
- Reset asserted during RESP: `ack` is still visible in that cycle; all state clears at the edge.
- Simultaneous `l_req` and `s_req`: round-robin decides, and the loser is served next.

## Configuration
Macro: `DMEM_ARB_ALIGN_CHECK_EN`.

When defined, the arbiter rejects an access as an error if any of these hold:
- the address is misaligned (word with addr[1:0]≠0, half with addr[0]=1);
- the size is 00;
- addr < `BASE_ADDR` or addr ≥ `BASE_ADDR` + 4×`DEPTH_WORDS`.

On a rejected access:
- the ACC cycle still occurs, but `mem_ena` is held at 0;
- `ack` is issued with `err`=1;
- `l_rdata` is set to 0.

When the macro is not defined:
- no checks are made and all accesses pass through to memory;
- `l_err` and `s_err` are constant 0.

## Test plan
- Reset with rst_n=0 for 2 cycles → all outputs 0. Then store word 32'hDEADBEEF to 32'h10010000 → `s_ack` high 2 cycles after the sampling edge, and `mem_ena`/`mem_wena`/`mem_w_cs`=01 high for exactly one cycle.
- Load byte at 32'h10010003 with sign=1 → `l_rdata`=32'hFFFFFFDE. With sign=0 → 32'h000000DE. Load half at 32'h10010000 with sign=1 → 32'hFFFFBEEF.
- `l_req` and `s_req` both raised from reset and held for 4 transactions → grant order L, S, L, S, and each `ack` goes only to the granted port.
- Reset asserted in the ACC cycle of a store of 32'h12345678 to 32'h10010004 → no write; a later load of that word returns its prior value, and no `s_ack` occurs.
- With the macro defined: word load at 32'h10010002 → `l_ack` with `l_err`=1, `mem_ena` never asserted. Store at 32'h10012000 → `s_err`=1.
- With the macro undefined: a misaligned half store at 32'h10010001 → memory is accessed and `s_err`=0.
